bike_syndrome_weight: RTL and testbench

- Computes the Hamming weight of the BIKE syndrome stored in block RAM. Reads WORD_WIDTH-bit words, popcounts each word, and accumulates the counts in a registered 48-bit adder stage (DSP add, P-register only).
- Sits directly upstream of the decoder's threshold/decision logic.
- The zero-weight flag tells the decoder that the syndrome is zero, i.e. decoding succeeded.

---
 rtl/bike_syndrome_weight_if.sv | 37 +++
 rtl/bike_syndrome_weight.sv | 128 ++++++++++++
 tb/tb_bike_syndrome_weight.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/bike_syndrome_weight_if.sv
// Bundles the start/status handshake, the syndrome RAM read port and the
// weight result of bike_syndrome_weight.
//   slave  : the weight engine (takes start and ram_dout, drives the rest)
//   master : the requester / RAM side (drives start and ram_dout)
// Signals:
//   start    : start request
//   busy     : run in progress
//   done     : one-cycle completion pulse
//   ram_ren  : syndrome RAM read enable
//   ram_addr : syndrome RAM read address
//   ram_dout : RAM read data, one cycle after ram_ren
//   weight   : syndrome Hamming weight
//   is_zero  : weight == 0
interface bike_syndrome_weight_if #(
  parameter int WORD_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 9,
  parameter int WEIGHT_WIDTH = 16
);
  logic                    start;
  logic                    busy;
  logic                    done;
  logic                    ram_ren;
  logic [ADDR_WIDTH-1:0]   ram_addr;
  logic [WORD_WIDTH-1:0]   ram_dout;
  logic [WEIGHT_WIDTH-1:0] weight;
  logic                    is_zero;

  modport master (
    output start, ram_dout,
    input  busy, done, ram_ren, ram_addr, weight, is_zero
  );

  modport slave (
    input  start, ram_dout,
    output busy, done, ram_ren, ram_addr, weight, is_zero
  );
endinterface

// File: rtl/bike_syndrome_weight.sv
// Hamming weight of the BIKE syndrome held in block RAM. Each RAM word is
// read once, popcounted (upper bits of the final word masked) and summed in
// a 48-bit registered accumulator. The result and a zero flag are reported
// with a one-cycle done pulse; a zero weight means decoding succeeded.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high reset
//   bus   : start/busy/done handshake, RAM read port, weight/is_zero result
module bike_syndrome_weight #(
  parameter int WORD_WIDTH     = 32,
  parameter int NUM_WORDS      = 386,
  parameter int LAST_WORD_BITS = 3,
  parameter int ADDR_WIDTH     = 9,
  parameter int WEIGHT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  bike_syndrome_weight_if.slave  bus
);

  localparam int PC_W  = $clog2(WORD_WIDTH + 1);
  localparam int ACC_W = 48;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

  function automatic logic [WORD_WIDTH-1:0] last_mask();
    logic [WORD_WIDTH-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < WORD_WIDTH; i++)
      m[i] = (int'(i) < LAST_WORD_BITS);
    return m;
  endfunction

  localparam logic [WORD_WIDTH-1:0] LAST_MASK = last_mask();

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   word_cnt;
  logic                    flush_cnt;
  logic                    rd_valid;   // ram_dout carries a requested word
  logic                    rd_last;    // ...and it is word NUM_WORDS-1
  logic [PC_W-1:0]         pc;
  logic                    pc_valid;
  logic [ACC_W-1:0]        acc;
  logic [ACC_W-1:0]        acc_next;
  logic [WORD_WIDTH-1:0]   masked;
  logic [PC_W-1:0]         pc_comb;

  assign bus.ram_ren  = (state == S_READ);
  assign bus.ram_addr = (state == S_READ) ? word_cnt : '0;

  always_comb begin
    masked  = rd_last ? (bus.ram_dout & LAST_MASK) : bus.ram_dout;
    pc_comb = '0;
    for (int unsigned i = 0; i < WORD_WIDTH; i++)
      pc_comb = pc_comb + PC_W'(masked[i]);
    acc_next = pc_valid ? (acc + ACC_W'(pc)) : acc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      word_cnt    <= '0;
      flush_cnt   <= 1'b0;
      rd_valid    <= 1'b0;
      rd_last     <= 1'b0;
      pc          <= '0;
      pc_valid    <= 1'b0;
      acc         <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.weight  <= '0;
      bus.is_zero <= 1'b0;
    end else begin
      rd_valid <= bus.ram_ren;
      rd_last  <= bus.ram_ren && (word_cnt == LAST_ADDR);
      pc       <= rd_valid ? pc_comb : '0;
      pc_valid <= rd_valid;
      acc      <= acc_next;
      bus.done <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            state       <= S_READ;
            word_cnt    <= '0;
            acc         <= '0;
            bus.busy    <= 1'b1;
            bus.weight  <= '0;
            bus.is_zero <= 1'b0;
          end
        end
        S_READ: begin
          if (word_cnt == LAST_ADDR) begin
            state     <= S_FLUSH;
            word_cnt  <= '0;
            flush_cnt <= 1'b0;
          end else begin
            word_cnt <= word_cnt + 1'b1;
          end
        end
        S_FLUSH: begin
          if (flush_cnt) begin
            // The final popcount is being added on this same edge, so the
            // result is taken from the adder output rather than from acc.
            state       <= S_DONE;
            bus.done    <= 1'b1;
            bus.weight  <= acc_next[WEIGHT_WIDTH-1:0];
            bus.is_zero <= (acc_next == '0);
          end else begin
            flush_cnt <= 1'b1;
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bike_syndrome_weight.sv
module tb_bike_syndrome_weight;

  localparam int WW  = 32;
  localparam int NW  = 386;
  localparam int AW  = 9;
  localparam int WTW = 16;
  localparam int unsigned LAT = NW + 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bike_syndrome_weight_if #(.WORD_WIDTH(WW), .ADDR_WIDTH(AW), .WEIGHT_WIDTH(WTW)) bus ();

  bike_syndrome_weight #(
    .WORD_WIDTH(WW),
    .NUM_WORDS(NW),
    .LAST_WORD_BITS(3),
    .ADDR_WIDTH(AW),
    .WEIGHT_WIDTH(WTW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // Syndrome RAM with one cycle read latency
  logic [WW-1:0] mem [NW];
  always @(posedge clk)
    if (bus.ram_ren) bus.ram_dout <= mem[bus.ram_addr];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WTW-1:0] w;
    logic           z;
    int unsigned    c;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: address sequence, cleared result while busy, done scoreboard
  int  reads = 0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (bus.ram_ren) begin
      chk("ram_addr", 64'(bus.ram_addr), 64'(reads));
      reads++;
    end
    if (bus.busy && !bus.done)
      chk("result_cleared", {bus.weight, bus.is_zero}, '0);
    if (prev_done)
      chk("busy_after_done", 64'(bus.busy), 64'd0);
    if (bus.done) begin
      chk("done_single_pulse", 64'(prev_done), 64'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("weight", 64'(bus.weight), 64'(e.w));
        chk("is_zero", 64'(bus.is_zero), 64'(e.z));
        chk("done_cycle", 64'(cyc), 64'(e.c));
        chk("read_count", 64'(reads), 64'(NW));
      end
      chk("busy_at_done", 64'(bus.busy), 64'd1);
      reads = 0;
      done_cnt++;
    end
    prev_done = bus.done;
    if (reset) reads = 0;
  end

  task automatic fill(input logic [WW-1:0] v);
    for (int i = 0; i < NW; i++) mem[i] = v;
  endtask

  task automatic wait_done(input int target);
    for (int k = 0; k < 600 && done_cnt < target; k++) @(posedge clk);
    chk("done_timeout", 64'(done_cnt >= target), 64'd1);
  endtask

  // Called at a rising edge; start is seen in IDLE during the following cycle.
  task automatic do_run(input logic [WTW-1:0] w, input logic z);
    int t;
    t = done_cnt + 1;
    #1;
    bus.start = 1'b1;
    sb.push_back('{w: w, z: z, c: cyc + LAT});
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(t);
  endtask

  task automatic check_outputs_clear(input string name);
    chk(name, {bus.busy, bus.done, bus.ram_ren, bus.ram_addr, bus.weight, bus.is_zero}, '0);
  endtask

  initial begin
    int unsigned c0;
    int n;
    bus.start = 1'b0;
    fill('0);
    repeat (3) @(posedge clk);
    #1;
    check_outputs_clear("reset_state");
    reset = 1'b0;
    @(posedge clk);

    // Directed content patterns
    fill('0);
    do_run(16'd0, 1'b1);
    @(posedge clk);
    fill('1);
    do_run(16'h3023, 1'b0);
    @(posedge clk);
    fill('0); mem[NW-1] = 32'h0000_0008;
    do_run(16'd0, 1'b1);
    @(posedge clk);
    fill('0); mem[NW-1] = 32'h0000_0004;
    do_run(16'd1, 1'b0);
    @(posedge clk);
    fill('0); mem[0] = 32'hFFFF_FFFF;
    do_run(16'd32, 1'b0);
    @(posedge clk);
    fill('0); mem[NW-1] = 32'hFFFF_FFFF;
    do_run(16'd3, 1'b0);
    @(posedge clk);
    fill('0); mem[10] = 32'h0F0F_0F0F; mem[200] = 32'h8000_0001; mem[NW-1] = 32'hFFFF_FFF7;
    do_run(16'd21, 1'b0);
    @(posedge clk);

    // Reset in the middle of a run: no done, then a clean restart
    fill('1);
    n = done_cnt;
    #1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_outputs_clear("abort_clear");
    repeat (400) @(posedge clk);
    chk("abort_no_done", 64'(done_cnt), 64'(n));
    do_run(16'h3023, 1'b0);
    @(posedge clk);

    // start held high: second run begins only in the IDLE cycle after DONE
    n = done_cnt;
    #1;
    bus.start = 1'b1;
    c0 = cyc;
    sb.push_back('{w: 16'h3023, z: 1'b0, c: c0 + LAT});
    repeat (LAT + 1) @(posedge clk);
    sb.push_back('{w: 16'h3023, z: 1'b0, c: c0 + LAT + 1 + LAT});
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(n + 2);
    repeat (3) @(posedge clk);

    // Back-to-back: all-ones then all-zero, second start right after DONE
    fill('1);
    do_run(16'h3023, 1'b0);
    fill('0);
    do_run(16'd0, 1'b1);

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
